// File: rtl/inv_sub_bytes_seq_if.sv
// inv_sub_bytes_seq_if: in/out valid-ready handshake and 4x4 byte states for inv_sub_bytes_seq.
// SBOX_FWD_MODE_EN adds the fwd_mode table-select input.
interface inv_sub_bytes_seq_if;
    logic                   in_valid;
    logic                   in_ready;
    logic [0:3][0:3][7:0]   in_state;
    logic                   out_valid;
    logic                   out_ready;
    logic [0:3][0:3][7:0]   out_state;
`ifdef SBOX_FWD_MODE_EN
    logic                   fwd_mode;
`endif

    modport master (
`ifdef SBOX_FWD_MODE_EN
        output fwd_mode,
`endif
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
`ifdef SBOX_FWD_MODE_EN
        input  fwd_mode,
`endif
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: iterative AES InvSubBytes, BYTES_PER_CYCLE bytes per clock, column-major order.
// Defining SBOX_FWD_MODE_EN adds fwd_mode, which selects the forward Sbox for a whole block.
module inv_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input logic               clk,
    input logic               rst,
    inv_sub_bytes_seq_if.slave bus
);
    localparam int B  = BYTES_PER_CYCLE;
    localparam int G  = 16 / B;
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    if (!(B inside {1, 2, 4, 8, 16})) begin : g_bad_bpc
        $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        grp_q, grp_d;
    logic [0:3][0:3][7:0] work_q, work_d;
    logic [0:3][0:3][7:0] last_q, last_d;
    logic [3:0]           idx;

`ifdef SBOX_FWD_MODE_EN
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    logic fwd_q;
    // Table select is captured with the state so one block never mixes tables.
    always_ff @(posedge clk) begin
        if (rst) fwd_q <= 1'b0;
        else if (state_q == IDLE && bus.in_valid) fwd_q <= bus.fwd_mode;
    end
    function automatic logic [7:0] sub(input logic [7:0] x);
        return fwd_q ? SBOX[x] : INV_SBOX[x];
    endfunction
`else
    function automatic logic [7:0] sub(input logic [7:0] x);
        return INV_SBOX[x];
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grp_q   <= '0;
            work_q  <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            work_q  <= work_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        work_d  = work_q;
        last_d  = last_q;
        idx     = '0;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                state_d = RUN;
                grp_d   = '0;
                work_d  = bus.in_state;
            end
            RUN: begin
                // Linear byte k lives at row k%4, column k/4.
                for (int j = 0; j < B; j++) begin
                    idx = 4'(int'(grp_q) * B + j);
                    work_d[idx[1:0]][idx[3:2]] = sub(work_q[idx[1:0]][idx[3:2]]);
                end
                state_d = (grp_q == GW'(G - 1)) ? DONE : RUN;
                grp_d   = (grp_q == GW'(G - 1)) ? grp_q : grp_q + 1'b1;
            end
            DONE: if (bus.out_ready) begin
                state_d = IDLE;
                last_d  = work_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE) && !rst;
        bus.out_valid = (state_q == DONE);
        bus.out_state = (state_q == DONE) ? work_q : last_q;
    end
endmodule
